sram_array_ctrl: RTL and testbench

- Initiator-side controller for the banked SRAM-cell array used by the CPU register storage.
- Accepts word-level write and dual-read requests over a valid/ready handshake.
- Decodes addresses into one-hot write/read selects and drives write data into the array.
- Captures both array read ports and returns them over a valid/ready response channel; serialises all accesses so ordering is exact.

---
 rtl/sram_array_ctrl_pkg.sv | 17 +
 rtl/addr_onehot_dec.sv | 24 ++
 rtl/sram_array_ctrl.sv | 131 +++++++++++++
 tb/tb_sram_array_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_array_ctrl_pkg.sv
// Shared definitions for the SRAM-cell array controller: FSM state encoding
// and default geometry of the array (address width, word count, word width).
// Imported by sram_array_ctrl and addr_onehot_dec.
package sram_array_ctrl_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int DEPTH_DEF  = 8;
   localparam int DATA_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

endpackage

// File: rtl/addr_onehot_dec.sv
// Purpose: binary address to one-hot word select; all zeros when addr >= DEPTH.
// Latency: combinational, zero cycles.
// Backpressure: none (pure decode).
// Ports: addr (ADDR_W) in, onehot (DEPTH) out.
module addr_onehot_dec
   import sram_array_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [DEPTH-1:0]  onehot
);

   // Only indices 0..DEPTH-1 are compared, so an out-of-range address
   // matches nothing and the select stays all zeros.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < DEPTH; i++) begin
         onehot[i] = (addr == ADDR_W'(i));
      end
   end

endmodule

// File: rtl/sram_array_ctrl.sv
// Purpose: serialising initiator for a banked SRAM-cell array (write / dual read).
// Latency: write ws in N+1, ready in N+2; read rs in N+1, rsp_valid in N+2.
// Backpressure: req_ready only in IDLE; response held in RESP until rsp_ready.
// Ports: clk, rst (async high); req_* request channel; rsp_* response channel;
//        ws/wd/rs1/rs2 drive the array, rd1/rd2 are its combinational read ports.
module sram_array_ctrl
   import sram_array_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_waddr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [ADDR_W-1:0] req_raddr1,
   input  logic [ADDR_W-1:0] req_raddr2,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata1,
   output logic [DATA_W-1:0] rsp_rdata2,
   output logic [DEPTH-1:0]  ws,
   output logic [DATA_W-1:0] wd,
   output logic [DEPTH-1:0]  rs1,
   output logic [DEPTH-1:0]  rs2,
   input  logic [DATA_W-1:0] rd1,
   input  logic [DATA_W-1:0] rd2
);

   state_t state, state_nxt;

   logic [DEPTH-1:0]  ws_dec, rs1_dec, rs2_dec;
   logic [DEPTH-1:0]  ws_nxt, rs1_nxt, rs2_nxt;
   logic [DATA_W-1:0] wd_nxt, rsp_rdata1_nxt, rsp_rdata2_nxt;
   logic              rsp_valid_nxt;
   logic              accept;

   addr_onehot_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_w  (.addr(req_waddr),  .onehot(ws_dec));
   addr_onehot_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_r1 (.addr(req_raddr1), .onehot(rs1_dec));
   addr_onehot_dec #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_r2 (.addr(req_raddr2), .onehot(rs2_dec));

   assign req_ready = (state == IDLE);
   assign accept    = req_valid & req_ready;

   // State register plus the registered array-side and response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ws         <= '0;
         wd         <= '0;
         rs1        <= '0;
         rs2        <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata1 <= '0;
         rsp_rdata2 <= '0;
      end else begin
         state      <= state_nxt;
         ws         <= ws_nxt;
         wd         <= wd_nxt;
         rs1        <= rs1_nxt;
         rs2        <= rs2_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_rdata1 <= rsp_rdata1_nxt;
         rsp_rdata2 <= rsp_rdata2_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = req_we ? WRITE : READ;
         WRITE:   state_nxt = IDLE;
         READ:    state_nxt = RESP;
         RESP:    if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: D-inputs of the output flops. Everything holds unless
   // the current state says otherwise; wd and the response data are left
   // holding after use so they never glitch on the array/consumer side.
   always_comb begin
      ws_nxt         = ws;
      wd_nxt         = wd;
      rs1_nxt        = rs1;
      rs2_nxt        = rs2;
      rsp_valid_nxt  = rsp_valid;
      rsp_rdata1_nxt = rsp_rdata1;
      rsp_rdata2_nxt = rsp_rdata2;
      case (state)
         IDLE: begin
            if (accept) begin
               if (req_we) begin
                  ws_nxt = ws_dec;
                  wd_nxt = req_wdata;
               end else begin
                  rs1_nxt = rs1_dec;
                  rs2_nxt = rs2_dec;
               end
            end
         end
         WRITE: begin
            // The cell latches at the end of this cycle; drop the select.
            ws_nxt = '0;
         end
         READ: begin
            // rd1/rd2 settle within this cycle from the registered selects.
            rsp_rdata1_nxt = rd1;
            rsp_rdata2_nxt = rd2;
            rs1_nxt        = '0;
            rs2_nxt        = '0;
            rsp_valid_nxt  = 1'b1;
         end
         RESP: begin
            if (rsp_ready) rsp_valid_nxt = 1'b0;
         end
         default: begin
            ws_nxt        = '0;
            rs1_nxt       = '0;
            rs2_nxt       = '0;
            rsp_valid_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: two instances (DEPTH 8 and DEPTH 6) run in
// lockstep on shared request/response inputs, each with its own array model
// and its own expected-response queue.
module tb_sram_array_ctrl;

   localparam int AW = 3;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_we = 1'b0;
   logic [AW-1:0] req_waddr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic [AW-1:0] req_raddr1 = '0;
   logic [AW-1:0] req_raddr2 = '0;
   logic          rsp_ready = 1'b1;

   logic          req_ready8, rsp_valid8;
   logic [DW-1:0] rsp_rdata1_8, rsp_rdata2_8, wd8, rd1_8, rd2_8;
   logic [7:0]    ws8, rs1_8, rs2_8;

   logic          req_ready6, rsp_valid6;
   logic [DW-1:0] rsp_rdata1_6, rsp_rdata2_6, wd6, rd1_6, rd2_6;
   logic [5:0]    ws6, rs1_6, rs2_6;

   always #5 clk = ~clk;

   sram_array_ctrl #(.ADDR_W(AW), .DEPTH(8), .DATA_W(DW)) u_dut8 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready8), .req_we(req_we),
      .req_waddr(req_waddr), .req_wdata(req_wdata),
      .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
      .rsp_valid(rsp_valid8), .rsp_ready(rsp_ready),
      .rsp_rdata1(rsp_rdata1_8), .rsp_rdata2(rsp_rdata2_8),
      .ws(ws8), .wd(wd8), .rs1(rs1_8), .rs2(rs2_8), .rd1(rd1_8), .rd2(rd2_8)
   );

   sram_array_ctrl #(.ADDR_W(AW), .DEPTH(6), .DATA_W(DW)) u_dut6 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready6), .req_we(req_we),
      .req_waddr(req_waddr), .req_wdata(req_wdata),
      .req_raddr1(req_raddr1), .req_raddr2(req_raddr2),
      .rsp_valid(rsp_valid6), .rsp_ready(rsp_ready),
      .rsp_rdata1(rsp_rdata1_6), .rsp_rdata2(rsp_rdata2_6),
      .ws(ws6), .wd(wd6), .rs1(rs1_6), .rs2(rs2_6), .rd1(rd1_6), .rd2(rd2_6)
   );

   // Array models: cells latch wd on the edge while selected; reads are an OR.
   logic [DW-1:0] arr8 [8];
   logic [DW-1:0] arr6 [6];

   always @(posedge clk) begin
      for (int i = 0; i < 8; i++) if (ws8[i]) arr8[i] <= wd8;
      for (int i = 0; i < 6; i++) if (ws6[i]) arr6[i] <= wd6;
   end

   always_comb begin
      rd1_8 = '0;
      rd2_8 = '0;
      rd1_6 = '0;
      rd2_6 = '0;
      for (int i = 0; i < 8; i++) begin
         if (rs1_8[i]) rd1_8 = rd1_8 | arr8[i];
         if (rs2_8[i]) rd2_8 = rd2_8 | arr8[i];
      end
      for (int i = 0; i < 6; i++) begin
         if (rs1_6[i]) rd1_6 = rd1_6 | arr6[i];
         if (rs2_6[i]) rd2_6 = rd2_6 | arr6[i];
      end
   end

   // Reference contents and scoreboards.
   logic [DW-1:0] ref8 [8];
   logic [DW-1:0] ref6 [6];
   logic [2*DW-1:0] q8 [$];
   logic [2*DW-1:0] q6 [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] exp8(input logic [AW-1:0] a);
      return ref8[a];
   endfunction

   function automatic logic [DW-1:0] exp6(input logic [AW-1:0] a);
      return (int'(a) < 6) ? ref6[a] : '0;
   endfunction

   // Response monitor and select invariants, sampled mid-cycle.
   always @(negedge clk) begin
      logic [2*DW-1:0] e;
      if (!rst) begin
         checks++;
         if ($countones(ws8) > 1 || $countones(rs1_8) > 1 || $countones(rs2_8) > 1 ||
             (ws8 != 0 && (rs1_8 | rs2_8) != 0) ||
             $countones(ws6) > 1 || $countones(rs1_6) > 1 || $countones(rs2_6) > 1 ||
             (ws6 != 0 && (rs1_6 | rs2_6) != 0)) begin
            errors++;
            $display("FAIL onehot: ws8=%b rs1_8=%b rs2_8=%b ws6=%b rs1_6=%b rs2_6=%b at cycle %0d",
                     ws8, rs1_8, rs2_8, ws6, rs1_6, rs2_6, cyc);
         end
         if (rsp_valid8 && rsp_ready) begin
            checks++;
            if (q8.size() == 0) begin
               errors++;
               $display("FAIL rsp8_unexpected: got %h/%h, no response expected", rsp_rdata1_8, rsp_rdata2_8);
            end else begin
               e = q8.pop_front();
               if ({rsp_rdata1_8, rsp_rdata2_8} !== e) begin
                  errors++;
                  $display("FAIL rsp8_data: got %h/%h expected %h/%h", rsp_rdata1_8, rsp_rdata2_8, e[15:8], e[7:0]);
               end
            end
         end
         if (rsp_valid6 && rsp_ready) begin
            checks++;
            if (q6.size() == 0) begin
               errors++;
               $display("FAIL rsp6_unexpected: got %h/%h, no response expected", rsp_rdata1_6, rsp_rdata2_6);
            end else begin
               e = q6.pop_front();
               if ({rsp_rdata1_6, rsp_rdata2_6} !== e) begin
                  errors++;
                  $display("FAIL rsp6_data: got %h/%h expected %h/%h", rsp_rdata1_6, rsp_rdata2_6, e[15:8], e[7:0]);
               end
            end
         end
      end
   end

   // Present a request and wait (bounded) for its accept edge; returns #1
   // after that edge. hold keeps req_valid high for a following request.
   task automatic do_req(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wdat,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2, input logic hold);
      bit acc = 0;
      req_we     = we;
      req_waddr  = wa;
      req_wdata  = wdat;
      req_raddr1 = ra1;
      req_raddr2 = ra2;
      req_valid  = 1'b1;
      for (int t = 0; t < 20 && !acc; t++) begin
         @(negedge clk);
         if (req_ready8) begin
            @(posedge clk);
            acc = 1;
         end
      end
      #1;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: request never accepted, required accept within 20 cycles");
         req_valid = 1'b0;
      end else begin
         acc_cyc = cyc;
         if (we) begin
            ref8[wa] = wdat;
            if (int'(wa) < 6) ref6[wa] = wdat;
         end else begin
            q8.push_back({exp8(ra1), exp8(ra2)});
            q6.push_back({exp6(ra1), exp6(ra2)});
         end
         if (!hold) req_valid = 1'b0;
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({ws8, rs1_8, rs2_8, wd8} !== 32'h0 || {ws6, rs1_6, rs2_6, wd6} !== 26'h0) begin
         errors++;
         $display("FAIL reset_sel: ws8=%h rs1_8=%h rs2_8=%h wd8=%h ws6=%h, required all 0", ws8, rs1_8, rs2_8, wd8, ws6);
      end
      checks++;
      if ({rsp_valid8, rsp_rdata1_8, rsp_rdata2_8} !== 17'h0 || rsp_valid6 !== 1'b0) begin
         errors++;
         $display("FAIL reset_rsp: rsp_valid8=%b d=%h/%h rsp_valid6=%b, required 0", rsp_valid8, rsp_rdata1_8, rsp_rdata2_8, rsp_valid6);
      end
      checks++;
      if (req_ready8 !== 1'b1 || req_ready6 !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: %b/%b, required 1", req_ready8, req_ready6);
      end
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      do_req(1'b1, 3'd3, 8'hA5, 3'd0, 3'd0, 1'b0);
      checks++;
      if (ws8 !== 8'b0000_1000 || wd8 !== 8'hA5 || ws6 !== 6'b00_1000) begin
         errors++;
         $display("FAIL wr_sel: ws8=%b wd8=%h ws6=%b, required 00001000/a5/001000", ws8, wd8, ws6);
      end
      next_cycle();
      checks++;
      if (ws8 !== 8'h00 || req_ready8 !== 1'b1 || wd8 !== 8'hA5) begin
         errors++;
         $display("FAIL wr_done: ws8=%b req_ready=%b wd8=%h, required 0/1/a5", ws8, req_ready8, wd8);
      end
      do_req(1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 1'b0);
      checks++;
      if (rs1_8 !== 8'b0000_1000 || rs2_8 !== 8'b0000_1000 || rsp_valid8 !== 1'b0) begin
         errors++;
         $display("FAIL rd_sel: rs1=%b rs2=%b rsp_valid=%b, required 00001000/00001000/0", rs1_8, rs2_8, rsp_valid8);
      end
      next_cycle();
      checks++;
      if (rsp_valid8 !== 1'b1 || rsp_rdata1_8 !== 8'hA5 || rsp_rdata2_8 !== 8'hA5 || rs1_8 !== 8'h00) begin
         errors++;
         $display("FAIL rd_rsp: valid=%b d=%h/%h rs1=%b, required 1/a5/a5/0", rsp_valid8, rsp_rdata1_8, rsp_rdata2_8, rs1_8);
      end
      next_cycle();
      checks++;
      if (rsp_valid8 !== 1'b0 || req_ready8 !== 1'b1) begin
         errors++;
         $display("FAIL rd_done: rsp_valid=%b req_ready=%b, required 0/1", rsp_valid8, req_ready8);
      end
   endtask

   task automatic test_dual_read();
      do_req(1'b1, 3'd0, 8'h11, 3'd0, 3'd0, 1'b0);
      do_req(1'b1, 3'd7, 8'h7E, 3'd0, 3'd0, 1'b0);
      do_req(1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 1'b0);
      checks++;
      if (rs1_8 !== 8'b0000_0001 || rs2_8 !== 8'b1000_0000 || rs2_6 !== 6'b0) begin
         errors++;
         $display("FAIL dual_sel: rs1=%b rs2=%b rs2_6=%b, required 00000001/10000000/000000", rs1_8, rs2_8, rs2_6);
      end
      next_cycle();
      next_cycle();
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      do_req(1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 1'b0);
      next_cycle();
      req_we    = 1'b1;
      req_waddr = 3'd5;
      req_wdata = 8'h55;
      req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         checks++;
         if (rsp_valid8 !== 1'b1 || rsp_rdata1_8 !== 8'h11 || rsp_rdata2_8 !== 8'h7E ||
             req_ready8 !== 1'b0 || ws8 !== 8'h00) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b d=%h/%h ready=%b ws=%b, required 1/11/7e/0/0",
                     k, rsp_valid8, rsp_rdata1_8, rsp_rdata2_8, req_ready8, ws8);
         end
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      next_cycle();
      checks++;
      if (rsp_valid8 !== 1'b0 || req_ready8 !== 1'b1) begin
         errors++;
         $display("FAIL bp_release: rsp_valid=%b req_ready=%b, required 0/1", rsp_valid8, req_ready8);
      end
   endtask

   task automatic test_out_of_range();
      do_req(1'b1, 3'd2, 8'h3C, 3'd0, 3'd0, 1'b0);
      do_req(1'b1, 3'd6, 8'hFF, 3'd0, 3'd0, 1'b0);
      checks++;
      if (ws6 !== 6'b0 || ws8 !== 8'b0100_0000) begin
         errors++;
         $display("FAIL oor_write: ws6=%b ws8=%b, required 000000/01000000", ws6, ws8);
      end
      next_cycle();
      do_req(1'b0, 3'd0, 8'h00, 3'd6, 3'd2, 1'b0);
      next_cycle();
      checks++;
      if (rsp_valid6 !== 1'b1 || rsp_rdata1_6 !== 8'h00 || rsp_rdata2_6 !== 8'h3C) begin
         errors++;
         $display("FAIL oor_read: valid=%b d=%h/%h, required 1/00/3c", rsp_valid6, rsp_rdata1_6, rsp_rdata2_6);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] a [4];
      logic [DW-1:0] d [4];
      int prev = 0;
      a = '{3'd1, 3'd4, 3'd5, 3'd6};
      d = '{8'h21, 8'h44, 8'h5A, 8'h6B};
      for (int k = 0; k < 4; k++) begin
         do_req(1'b1, a[k], d[k], 3'd0, 3'd0, (k < 3));
         if (k > 0) begin
            checks++;
            if (acc_cyc - prev !== 2) begin
               errors++;
               $display("FAIL b2b_spacing%0d: %0d cycles between accepts, required 2", k, acc_cyc - prev);
            end
         end
         prev = acc_cyc;
      end
      next_cycle();
      do_req(1'b0, 3'd0, 8'h00, 3'd1, 3'd4, 1'b0);
      do_req(1'b0, 3'd0, 8'h00, 3'd5, 3'd6, 1'b0);
      next_cycle();
      next_cycle();
   endtask

   task automatic test_reset_mid_read();
      do_req(1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 1'b0);
      rst = 1'b1;
      #1;
      checks++;
      if (ws8 !== 8'h0 || rs1_8 !== 8'h0 || rs2_8 !== 8'h0 || rsp_valid8 !== 1'b0 || req_ready8 !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset: ws=%b rs1=%b rs2=%b rsp_valid=%b req_ready=%b, required 0/0/0/0/1",
                  ws8, rs1_8, rs2_8, rsp_valid8, req_ready8);
      end
      q8.delete();
      q6.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_req(1'b0, 3'd0, 8'h00, 3'd3, 3'd7, 1'b0);
      next_cycle();
      checks++;
      if (rsp_valid8 !== 1'b1 || rsp_rdata1_8 !== 8'hA5 || rsp_rdata2_8 !== 8'h7E) begin
         errors++;
         $display("FAIL post_reset_read: valid=%b d=%h/%h, required 1/a5/7e", rsp_valid8, rsp_rdata1_8, rsp_rdata2_8);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 50 && (q8.size() != 0 || q6.size() != 0); t++) next_cycle();
      checks++;
      if (q8.size() != 0 || q6.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d/%0d responses outstanding, required 0", q8.size(), q6.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) ref8[i] = '0;
      for (int i = 0; i < 6; i++) ref6[i] = '0;
      test_reset();
      test_write_read();
      test_dual_read();
      test_backpressure();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_read();
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
